// File: rtl/tx_port_txn_scheduler_pkg.sv
// Shared state encodings, transaction parameter bundle and counter helper
// for the TX port transaction scheduler.
package tx_sched_pkg;

    localparam int C_TXSCHED_CNT_WIDTH = 32;

    typedef enum logic [4:0] {
        S_TXSCHED_IDLE  = 5'b00001,
        S_TXSCHED_GRANT = 5'b00010,
        S_TXSCHED_REQ   = 5'b00100,
        S_TXSCHED_XFER  = 5'b01000,
        S_TXSCHED_DRAIN = 5'b10000
    } txsched_state_e;

    typedef struct packed {
        logic        last;
        logic [30:0] off;
        logic [31:0] len;
    } txn_params_t;

    // Saturating increment so a stuck transaction never wraps back below the timeout.
    function automatic logic [C_TXSCHED_CNT_WIDTH-1:0] sat_inc(
        input logic [C_TXSCHED_CNT_WIDTH-1:0] v
    );
        return (v == {C_TXSCHED_CNT_WIDTH{1'b1}}) ? v : v + C_TXSCHED_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tx_port_txn_scheduler_rr_arbiter_mask.sv
// Combinational round-robin pick: the first request after i_last (wrapping)
// wins, so the previous winner is considered last.
module rr_arbiter_mask
    import tx_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    logic w_take;

    // Walk candidates in priority order starting just above the last winner.
    always_comb begin
        o_gnt   = {N{1'b0}};
        o_idx   = {W{1'b0}};
        o_valid = 1'b0;
        w_take  = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int j = 0; j < N; j++) begin
                w_take   = !o_valid && i_req[j] && (j == ((int'(i_last) + off) % N));
                o_gnt[j] = o_gnt[j] | w_take;
                o_idx    = w_take ? W'(j) : o_idx;
                o_valid  = o_valid | w_take;
            end
        end
    end

endmodule

// File: rtl/tx_port_txn_scheduler.sv
// Shares one TX engine between C_NUM_CHNL channel transaction monitors:
// round-robin grant, parameter hand-off, completion tracking, error/timeout abort.
module tx_port_txn_scheduler
    import tx_sched_pkg::*;
#(
    parameter int C_NUM_CHNL   = 4,
    parameter int C_CHNL_WIDTH = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1,
    parameter int C_TIMEOUT    = 1024
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [C_NUM_CHNL-1:0]     CHNL_TXN,
    output logic [C_NUM_CHNL-1:0]     CHNL_ACK,
    input  logic [C_NUM_CHNL-1:0]     CHNL_LAST,
    input  logic [32*C_NUM_CHNL-1:0]  CHNL_LEN,
    input  logic [31*C_NUM_CHNL-1:0]  CHNL_OFF,
    input  logic [C_NUM_CHNL-1:0]     CHNL_DONE,
    output logic [C_NUM_CHNL-1:0]     CHNL_ERR,
    output logic                      TX_REQ,
    input  logic                      TX_REQ_ACK,
    output logic [C_CHNL_WIDTH-1:0]   TX_CHNL,
    output logic [31:0]               TX_LEN,
    output logic [30:0]               TX_OFF,
    output logic                      TX_LAST,
    input  logic                      TX_DONE,
    input  logic                      TX_ERR,
    output logic                      BUSY
);

    txsched_state_e                 r_state;
    txsched_state_e                 w_state_nxt;
    logic [C_NUM_CHNL-1:0]          r_ack, r_err, w_ack_nxt, w_err_nxt;
    logic                           r_tx_req, w_req_nxt, r_busy;
    logic [C_CHNL_WIDTH-1:0]        r_chnl, r_last_grant;
    txn_params_t                    r_params, w_win;
    logic [C_TXSCHED_CNT_WIDTH-1:0] r_cnt;
    logic [1:0]                     r_age;
    logic                           w_load, w_cnt_clr, w_lastg_upd, w_timeout;
    logic [C_NUM_CHNL-1:0]          w_gnt_onehot, w_sel_mask;
    logic [C_CHNL_WIDTH-1:0]        w_gnt_idx;
    logic                           w_gnt_valid, w_sel_done, w_done_ok;

    rr_arbiter_mask #(.N(C_NUM_CHNL), .W(C_CHNL_WIDTH)) u_arb (
        .i_req   (CHNL_TXN),
        .i_last  (r_last_grant),
        .o_gnt   (w_gnt_onehot),
        .o_idx   (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    // Winner parameter mux and decode of the currently granted channel.
    always_comb begin
        w_win      = {$bits(txn_params_t){1'b0}};
        w_sel_mask = {C_NUM_CHNL{1'b0}};
        w_sel_done = 1'b0;
        for (int j = 0; j < C_NUM_CHNL; j++) begin
            w_win.len     = w_win.len  | (CHNL_LEN[32*j +: 32] & {32{w_gnt_onehot[j]}});
            w_win.off     = w_win.off  | (CHNL_OFF[31*j +: 31] & {31{w_gnt_onehot[j]}});
            w_win.last    = w_win.last | (CHNL_LAST[j] & w_gnt_onehot[j]);
            w_sel_mask[j] = (r_chnl == C_CHNL_WIDTH'(j));
            w_sel_done    = w_sel_done | (CHNL_DONE[j] & w_sel_mask[j]);
        end
    end

    // DONE stays stale-high until the channel reaches its read state, so ignore it
    // until two cycles after the ACK pulse.
    assign w_done_ok = w_sel_done && (r_age == 2'd2);
    assign w_timeout = (C_TIMEOUT != 0) && (sat_inc(r_cnt) == 32'(C_TIMEOUT));

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = {C_NUM_CHNL{1'b0}};
        w_err_nxt   = {C_NUM_CHNL{1'b0}};
        w_req_nxt   = r_tx_req;
        w_load      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_lastg_upd = 1'b0;
        case (r_state)
            S_TXSCHED_IDLE: begin
                if (w_gnt_valid) begin
                    w_ack_nxt   = w_gnt_onehot;
                    w_load      = 1'b1;
                    w_state_nxt = S_TXSCHED_GRANT;
                end else begin
                    w_state_nxt = S_TXSCHED_IDLE;
                end
            end
            S_TXSCHED_GRANT: begin
                w_lastg_upd = 1'b1;
                if (r_params.len == 32'd0) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_TXSCHED_DRAIN;
                end else begin
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_TXSCHED_REQ;
                end
            end
            S_TXSCHED_REQ: begin
                if (TX_ERR) begin
                    w_err_nxt   = w_sel_mask;
                    w_req_nxt   = 1'b0;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_TXSCHED_DRAIN;
                end else if (TX_REQ_ACK) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_TXSCHED_XFER;
                end else begin
                    w_state_nxt = S_TXSCHED_REQ;
                end
            end
            S_TXSCHED_XFER: begin
                if (TX_ERR || (!TX_DONE && w_timeout)) begin
                    w_err_nxt   = w_sel_mask;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_TXSCHED_DRAIN;
                end else if (TX_DONE) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_TXSCHED_DRAIN;
                end else begin
                    w_state_nxt = S_TXSCHED_XFER;
                end
            end
            S_TXSCHED_DRAIN: begin
                if (w_done_ok) begin
                    w_state_nxt = S_TXSCHED_IDLE;
                end else if (w_timeout) begin
                    w_err_nxt   = w_sel_mask;
                    w_state_nxt = S_TXSCHED_IDLE;
                end else begin
                    w_state_nxt = S_TXSCHED_DRAIN;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_TXSCHED_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_TXSCHED_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, latched parameters, arbitration history and counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ack        <= {C_NUM_CHNL{1'b0}};
            r_err        <= {C_NUM_CHNL{1'b0}};
            r_tx_req     <= 1'b0;
            r_busy       <= 1'b0;
            r_chnl       <= {C_CHNL_WIDTH{1'b0}};
            r_params     <= {$bits(txn_params_t){1'b0}};
            r_last_grant <= C_CHNL_WIDTH'(C_NUM_CHNL - 1);
            r_cnt        <= {C_TXSCHED_CNT_WIDTH{1'b0}};
            r_age        <= 2'd0;
        end else begin
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            r_tx_req <= w_req_nxt;
            r_busy   <= (w_state_nxt != S_TXSCHED_IDLE);
            if (w_load) begin
                r_chnl   <= w_gnt_idx;
                r_params <= w_win;
                r_age    <= 2'd0;
            end else if (r_age != 2'd2) begin
                r_age <= r_age + 2'd1;
            end
            if (w_lastg_upd) begin
                r_last_grant <= r_chnl;
            end
            if (w_cnt_clr) begin
                r_cnt <= {C_TXSCHED_CNT_WIDTH{1'b0}};
            end else if ((r_state == S_TXSCHED_XFER) || (r_state == S_TXSCHED_DRAIN)) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end
    end

    assign CHNL_ACK = r_ack;
    assign CHNL_ERR = r_err;
    assign TX_REQ   = r_tx_req;
    assign TX_CHNL  = r_chnl;
    assign TX_LEN   = r_params.len;
    assign TX_OFF   = r_params.off;
    assign TX_LAST  = r_params.last;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_tx_port_txn_scheduler.sv
// Self-checking bench: directed scenarios plus randomized transactions checked
// against a transaction-level model of grant order, hand-off and completion timing.
module tb_tx_port_txn_scheduler;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [N-1:0]    CHNL_TXN = '0, CHNL_ACK, CHNL_LAST = '0, CHNL_DONE = '0, CHNL_ERR;
    logic [32*N-1:0] CHNL_LEN = '0;
    logic [31*N-1:0] CHNL_OFF = '0;
    logic            TX_REQ, TX_REQ_ACK = 1'b0, TX_LAST, TX_DONE = 1'b0, TX_ERR = 1'b0, BUSY;
    logic [1:0]      TX_CHNL;
    logic [31:0]     TX_LEN;
    logic [30:0]     TX_OFF;

    logic [31:0] len_a  [N];
    logic [30:0] off_a  [N];
    logic        last_a [N];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_g = N - 1;

    tx_port_txn_scheduler #(.C_NUM_CHNL(N), .C_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .CHNL_TXN(CHNL_TXN), .CHNL_ACK(CHNL_ACK),
        .CHNL_LAST(CHNL_LAST), .CHNL_LEN(CHNL_LEN), .CHNL_OFF(CHNL_OFF),
        .CHNL_DONE(CHNL_DONE), .CHNL_ERR(CHNL_ERR), .TX_REQ(TX_REQ),
        .TX_REQ_ACK(TX_REQ_ACK), .TX_CHNL(TX_CHNL), .TX_LEN(TX_LEN), .TX_OFF(TX_OFF),
        .TX_LAST(TX_LAST), .TX_DONE(TX_DONE), .TX_ERR(TX_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            CHNL_LEN[32*i +: 32] = len_a[i];
            CHNL_OFF[31*i +: 31] = off_a[i];
            CHNL_LAST[i]         = last_a[i];
        end
    endtask

    task automatic set_chnl(input int c, input logic [31:0] len, input logic [30:0] off, input logic last);
        len_a[c] = len; off_a[c] = off; last_a[c] = last;
        pack();
    endtask

    task automatic rand_params(input int c);
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0)      len_a[c] = 32'd0;
        else if (sel == 1) len_a[c] = 32'h8000_0000;
        else               len_a[c] = $urandom;
        off_a[c]  = 31'($urandom);
        last_a[c] = 1'($urandom_range(0, 1));
    endtask

    // Spec rule: first requester searching upward from last grant + 1, modulo N.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        int r;
        r = int'(req);
        for (int k = 1; k <= N; k++)
            if (((r >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        return -1;
    endfunction

    task automatic apply_reset();
        RST_N = 1'b0;
        tick();
        tick();
        chk("rst_ack",  64'(CHNL_ACK), 64'd0);
        chk("rst_err",  64'(CHNL_ERR), 64'd0);
        chk("rst_req",  64'(TX_REQ),   64'd0);
        chk("rst_busy", 64'(BUSY),     64'd0);
        chk("rst_tx",   64'({TX_CHNL, TX_LEN, TX_OFF, TX_LAST}), 64'd0);
        RST_N  = 1'b1;
        last_g = N - 1;
    endtask

    // One whole transaction. done_at/err_at: XFER cycle index of TX_DONE/TX_ERR (-1 never);
    // cdone_at: DRAIN cycle index from which CHNL_DONE is high (-1 never).
    task automatic do_txn(input int req_wait, input int done_at, input int err_at,
                          input bit req_err, input int cdone_at, input bit drop_txn);
        int ch, ack_cyc, k;
        bit left, exp_err, done_ok;
        logic [63:0] m;
        ch = rr_pick(CHNL_TXN, last_g);
        if (ch < 0) return;
        m = 64'd1 << ch;
        TX_ERR = 1'($urandom_range(0, 1));
        tick();
        TX_ERR  = 1'b0;
        ack_cyc = cyc;
        chk("ack",      64'(CHNL_ACK), m);
        chk("busy",     64'(BUSY),     64'd1);
        chk("tx_chnl",  64'(TX_CHNL),  64'(ch));
        chk("tx_len",   64'(TX_LEN),   64'(len_a[ch]));
        chk("tx_off",   64'(TX_OFF),   64'(off_a[ch]));
        chk("tx_last",  64'(TX_LAST),  64'(last_a[ch]));
        if (drop_txn) CHNL_TXN[ch] = 1'b0;
        TX_ERR = 1'($urandom_range(0, 1));
        tick();
        TX_ERR = 1'b0;
        chk("ack_pulse", 64'(CHNL_ACK), 64'd0);
        chk("err_grant", 64'(CHNL_ERR), 64'd0);
        chk("req_rise",  64'(TX_REQ),   64'(len_a[ch] != 32'd0));
        if (len_a[ch] != 32'd0) begin
            for (int i = 0; i < req_wait; i++) begin
                tick();
                chk("req_hold", 64'(TX_REQ), 64'd1);
                chk("tx_stable", 64'({TX_CHNL, TX_LEN, TX_OFF, TX_LAST}),
                    64'({2'(ch), len_a[ch], off_a[ch], last_a[ch]}));
            end
            TX_REQ_ACK = 1'b1;
            TX_ERR     = req_err;
            tick();
            TX_REQ_ACK = 1'b0;
            TX_ERR     = 1'b0;
            chk("req_drop", 64'(TX_REQ),   64'd0);
            chk("req_err",  64'(CHNL_ERR), req_err ? m : 64'd0);
            if (!req_err) begin
                k = 0; left = 1'b0;
                while (!left) begin
                    TX_ERR  = (k == err_at);
                    TX_DONE = (k == done_at);
                    CHNL_DONE[ch] = (k == done_at) && (cdone_at == 0);
                    tick();
                    TX_ERR = 1'b0; TX_DONE = 1'b0;
                    exp_err = (k == err_at) || ((k != done_at) && (k == TO - 1));
                    left    = (k == err_at) || (k == done_at) || (k == TO - 1);
                    if (left) begin
                        chk("xfer_err", 64'(CHNL_ERR), exp_err ? m : 64'd0);
                        chk("xfer_req", 64'(TX_REQ), 64'd0);
                    end
                    k++;
                end
            end
        end
        k = 0; left = 1'b0;
        while (!left) begin
            CHNL_DONE[ch] = (cdone_at >= 0) && (k >= cdone_at);
            done_ok = CHNL_DONE[ch] && (cyc >= ack_cyc + 2);
            tick();
            left    = done_ok || (k == TO - 1);
            exp_err = !done_ok && (k == TO - 1);
            chk("drain_busy", 64'(BUSY), 64'(!left));
            if (left) begin
                chk("drain_err", 64'(CHNL_ERR), exp_err ? m : 64'd0);
                chk("drain_req", 64'(TX_REQ | (|CHNL_ACK)), 64'd0);
            end
            k++;
        end
        CHNL_DONE = '0;
        last_g = ch;
    endtask

    initial begin
        int d_at, e_at;
        for (int i = 0; i < N; i++) begin
            len_a[i] = 32'd0; off_a[i] = 31'd0; last_a[i] = 1'b0;
        end
        apply_reset();

        set_chnl(0, 32'd16, 31'h10, 1'b1);
        CHNL_TXN = 4'b0001;
        do_txn(3, 2, -1, 1'b0, 1, 1'b1);

        apply_reset();
        for (int i = 0; i < N; i++) set_chnl(i, 32'd4 + 32'(i), 31'(i * 64), 1'(i));
        CHNL_TXN = 4'b1111;
        for (int i = 0; i < 5; i++) do_txn(0, 1, -1, 1'b0, 1, 1'b0);
        CHNL_TXN = '0;

        set_chnl(2, 32'd0, 31'h55, 1'b1);
        CHNL_TXN = 4'b0100;
        do_txn(0, 0, -1, 1'b0, 0, 1'b1);

        set_chnl(1, 32'd9, 31'h7, 1'b0);
        CHNL_TXN = 4'b0010;
        do_txn(0, -1, 5, 1'b0, 2, 1'b1);

        set_chnl(3, 32'd4, 31'h3, 1'b1);
        CHNL_TXN = 4'b1000;
        do_txn(1, -1, -1, 1'b0, 1, 1'b1);
        CHNL_TXN = 4'b0001;
        do_txn(0, 1, -1, 1'b0, -1, 1'b1);
        CHNL_TXN = 4'b0010;
        do_txn(2, 3, -1, 1'b1, 1, 1'b1);
        CHNL_TXN = 4'b0100;
        set_chnl(2, 32'd12, 31'h9, 1'b0);
        do_txn(0, 3, -1, 1'b0, 0, 1'b1);

        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N; c++) begin
                if (!CHNL_TXN[c] && ($urandom_range(0, 1) == 1)) begin
                    rand_params(c);
                    CHNL_TXN[c] = 1'b1;
                end
            end
            if (CHNL_TXN == '0) begin
                rand_params(0);
                CHNL_TXN[0] = 1'b1;
            end
            pack();
            d_at = $urandom_range(0, 5);
            e_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            if (e_at == d_at) e_at = -1;
            do_txn($urandom_range(0, 3), d_at, e_at, ($urandom_range(0, 9) == 0),
                   $urandom_range(0, 4), 1'b1);
        end
        CHNL_TXN = '0;
        tick();

        set_chnl(2, 32'd5, 31'h21, 1'b0);
        CHNL_TXN = 4'b0100;
        tick();
        CHNL_TXN = '0;
        tick();
        TX_REQ_ACK = 1'b1;
        tick();
        TX_REQ_ACK = 1'b0;
        tick();
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst_req",  64'(TX_REQ),   64'd0);
        chk("arst_ack",  64'(CHNL_ACK), 64'd0);
        chk("arst_err",  64'(CHNL_ERR), 64'd0);
        chk("arst_busy", 64'(BUSY),     64'd0);
        chk("arst_len",  64'(TX_LEN),   64'd0);
        last_g = N - 1;
        tick();
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < N; i++) set_chnl(i, 32'd3, 31'(i), 1'b1);
        CHNL_TXN = 4'b1101;
        do_txn(0, 1, -1, 1'b0, 1, 1'b1);
        CHNL_TXN = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tx_port_txn_scheduler.md
Name: tx_port_txn_scheduler

Overview:
- Shares one TX engine between C_NUM_CHNL transaction monitors. Each monitor presents TXN/LAST/LEN/OFF and waits for ACK.
- Selects one requesting channel round-robin, acknowledges it, forwards its parameters to the TX engine and holds the grant until both engine and channel report completion.
- Sits between the per-channel transaction monitors and the shared TX request/formatting engine.

Parameters:
C_NUM_CHNL, 4, number of requesting channels (1..12)
C_CHNL_WIDTH, clog2s(C_NUM_CHNL) (min 1), width of channel index
C_TIMEOUT, 1024, cycles the scheduler waits in XFER/DRAIN before forcing an abort (0 disables)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
CHNL_TXN  in  C_NUM_CHNL  channel i has valid transaction parameters
CHNL_ACK  out  C_NUM_CHNL  one-cycle parameter-accepted pulse to channel i
CHNL_LAST  in  C_NUM_CHNL  per-channel last flag
CHNL_LEN  in  32*C_NUM_CHNL  per-channel length in 32-bit words, channel i at [32i+31:32i]
CHNL_OFF  in  31*C_NUM_CHNL  per-channel offset, channel i at [31i+30:31i]
CHNL_DONE  in  C_NUM_CHNL  channel i transaction closed
CHNL_ERR  out  C_NUM_CHNL  one-cycle error pulse to channel i
TX_REQ  out  1  request to TX engine, held until accepted
TX_REQ_ACK  in  1  engine accepted TX_CHNL/TX_LEN/TX_OFF/TX_LAST
TX_CHNL  out  C_CHNL_WIDTH  granted channel index
TX_LEN  out  32  latched length
TX_OFF  out  31  latched offset
TX_LAST  out  1  latched last flag
TX_DONE  in  1  engine finished sending the granted transaction
TX_ERR  in  1  engine error on current transaction
BUSY  out  1  state != IDLE

Behaviour:
- Reset (async on RST_N low, release is synchronous in effect):
  - State = IDLE.
  - CHNL_ACK = 0, CHNL_ERR = 0, TX_REQ = 0, TX_CHNL/TX_LEN/TX_OFF/TX_LAST = 0, BUSY = 0.
  - rLastGrant = C_NUM_CHNL-1, so channel 0 wins first.
  - Reset mid-transaction drops everything; no pulses are emitted.
- All outputs are registered. The FSM is one-hot: IDLE, GRANT, REQ, XFER, DRAIN.
- IDLE:
  - If any CHNL_TXN bit is set, pick the winner: first set bit searching from rLastGrant+1 upward, wrapping modulo C_NUM_CHNL.
  - At the same edge: latch winner index and its LAST/LEN/OFF into TX_*, set CHNL_ACK[winner] = 1, go to GRANT.
  - Latency from TXN to ACK is 1 cycle.
- GRANT:
  - Deassert CHNL_ACK (exactly one-cycle pulse). rLastGrant <= winner.
  - If TX_LEN == 0, go to DRAIN (no engine request). Otherwise set TX_REQ = 1 and go to REQ.
- REQ:
  - Hold TX_REQ and TX_* stable until TX_REQ_ACK is sampled high.
  - Then drop TX_REQ and go to XFER.
  - If TX_ERR and TX_REQ_ACK are high together, TX_ERR wins: go to the abort path.
- XFER:
  - Wait for TX_DONE.
  - When TX_DONE is seen, go to DRAIN.
  - TX_DONE and CHNL_DONE[sel] may both be high in the same cycle; this is legal and goes straight to DRAIN, completing next cycle.
- DRAIN:
  - Wait for CHNL_DONE[sel], then go to IDLE.
  - CHNL_DONE is never sampled earlier than 2 cycles after the ACK pulse, because the channel's DONE is stale (high) until it enters its read state.
- Abort path:
  - TX_ERR in REQ or XFER: pulse CHNL_ERR[sel] for one cycle, drop TX_REQ, go to DRAIN.
  - TX_ERR in IDLE or GRANT is ignored.
- Timeout:
  - A 32-bit cycle counter clears on entry to XFER and counts in XFER and DRAIN.
  - When it reaches C_TIMEOUT (if non-zero), pulse CHNL_ERR[sel].
  - From XFER the timeout goes to DRAIN. From DRAIN it goes to IDLE unconditionally.
  - The counter saturates and does not wrap.
- Fairness and selection:
  - A channel whose TXN is still high in the cycle after its ACK is not re-granted until the current transaction completes.
  - Selection only happens in IDLE; requests arriving mid-transaction wait.
  - The next grant after channel k considers k last.
- Widths: LEN comparison against zero is a full 32-bit compare. TX_CHNL is zero-extended when C_NUM_CHNL is not a power of two.

Decomposition:
- Shared package tx_sched_pkg holds:
  - state one-hot encodings S_TXSCHED_IDLE..S_TXSCHED_DRAIN (5 bits);
  - a struct typedef txn_params_t {last, off[30:0], len[31:0]};
  - localparam C_TXSCHED_CNT_WIDTH = 32.
- One natural sub-module: rr_arbiter_mask.
  - Combinational round-robin priority pick from a request vector and last-grant index.
  - Returns a one-hot grant and a binary index.
  - Reusable by other channel-sharing blocks.

Test Plan:
- Single request: CHNL_TXN=4'b0001, LEN=16, OFF=0x10, LAST=1.
  - Expect CHNL_ACK[0] pulse 1 cycle later, then TX_REQ with TX_CHNL=0/TX_LEN=16/TX_OFF=0x10/TX_LAST=1.
  - Hold TX_REQ_ACK low 3 cycles: TX_REQ stays high and TX_* stay stable.
  - Then TX_DONE, then CHNL_DONE[0]: BUSY falls and state returns to IDLE.
- Round-robin: all four TXN held high, each completes normally.
  - Expect grant order 0,1,2,3,0.
  - Expect exactly one ACK pulse per grant and no two ACK bits set together.
- Zero length: channel 2, LEN=0.
  - Expect ACK[2], no TX_REQ ever, then completion on CHNL_DONE[2].
- Engine error: TX_ERR asserted 5 cycles into XFER for channel 1.
  - Expect a one-cycle CHNL_ERR[1] pulse and TX_REQ low.
  - Scheduler waits for CHNL_DONE[1] before next grant.
- Timeout: C_TIMEOUT=8, TX_DONE never asserted.
  - Expect CHNL_ERR pulse 8 cycles after XFER entry, then DRAIN.
  - Separately, with CHNL_DONE stuck low in DRAIN, expect a forced return to IDLE after 8 more cycles.
- Async reset: assert RST_N low in XFER between clock edges.
  - Expect TX_REQ/ACK/ERR/BUSY at 0 immediately.
  - After release, channel 0 has priority again.
